// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit
//   Instruction fetch stage for the RV32I pipeline. Issues in-order word
//   requests to instruction memory, tolerates pipelined multi-cycle latency,
//   buffers returned words in a first-word-fall-through prefetch FIFO and
//   hands {inst, pc, fault, misalign} to Decode over valid/ready. A redirect
//   empties the FIFO and discards every response still in flight.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   i_flush, i_jump_addr        redirect request and target
//   o_imem_req_valid/_addr      request to instruction memory
//   i_imem_req_ready            memory accepts the request
//   i_imem_rsp_valid/_data/_err in-order response, no backpressure
//   o_if_valid, i_id_ready      entry handshake toward Decode
//   o_if_inst, o_if_pc          instruction and its PC (0 when not valid)
//   o_if_fault, o_if_misalign   access fault / misaligned-target flags
//
// FSM
//   state    | meaning
//   ST_FETCH | requests issue whenever credit allows
//   ST_HALT  | misaligned redirect seen; no requests until an aligned flush

module if_prefetch_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     FIFO_DEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_jump_addr,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_imem_rsp_err,
  output logic            o_if_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_if_inst,
  output logic [XLEN-1:0] o_if_pc,
  output logic            o_if_fault,
  output logic            o_if_misalign
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_fetch_en;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;

  logic [XLEN-1:0] r_inst_mem  [FIFO_DEPTH];
  logic [XLEN-1:0] r_pc_mem    [FIFO_DEPTH];
  logic            r_fault_mem [FIFO_DEPTH];
  logic            r_mis_mem   [FIFO_DEPTH];

  logic [CW:0]     w_inflight;
  logic            w_mis;
  logic            w_req_fire;
  logic            w_rsp_fire;
  logic            w_rsp_drop;
  logic            w_push_rsp;
  logic            w_push_mis;
  logic            w_pop;
  logic            w_wr_en;
  logic [PW-1:0]   w_wr_idx;
  logic [XLEN-1:0] w_wr_inst;
  logic [XLEN-1:0] w_wr_pc;
  logic            w_wr_fault;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) w_state_nxt = w_mis ? ST_HALT : ST_FETCH;
  end

  always_comb begin
    w_fetch_en = (r_state == ST_FETCH);
  end

  // ---------------- request / response control ----------------
  assign w_mis      = (i_jump_addr[1:0] != 2'b00);
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};

  // Built from registers only; rst_n gating keeps the port quiet in reset.
  assign o_imem_req_valid = rst_n && w_fetch_en && (w_inflight < DEPTH_W)
                            && (r_drop_cnt == '0);
  assign o_imem_req_addr  = r_fetch_pc;

  assign w_req_fire = o_imem_req_valid && i_imem_req_ready;
  assign w_rsp_fire = i_imem_rsp_valid;
  assign w_rsp_drop = w_rsp_fire && (r_drop_cnt != '0);
  // A response landing in the flush cycle belongs to the old stream.
  assign w_push_rsp = w_rsp_fire && (r_drop_cnt == '0) && !i_flush;
  assign w_push_mis = i_flush && w_mis;
  assign w_pop      = o_if_valid && i_id_ready && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_rsp_pc      <= RESET_VECTOR;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
      if (i_flush) begin
        // Everything still owed by memory after this edge is stale.
        r_drop_cnt <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
        r_rd_ptr   <= '0;
        r_wr_ptr   <= w_push_mis ? PW'(1) : '0;
        r_count    <= w_push_mis ? CW'(1) : '0;
        if (!w_mis) begin
          r_fetch_pc <= i_jump_addr;
          r_rsp_pc   <= i_jump_addr;
        end
      end else begin
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push_rsp) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(4);
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push_rsp) - CW'(w_pop);
      end
    end
  end

  // ---------------- prefetch storage ----------------
  // The misaligned marker is written to slot 0 because the flush also
  // rewinds both pointers.
  assign w_wr_en    = w_push_rsp || w_push_mis;
  assign w_wr_idx   = i_flush ? '0 : r_wr_ptr;
  assign w_wr_inst  = w_push_mis ? '0 : i_imem_rsp_data;
  assign w_wr_pc    = w_push_mis ? i_jump_addr : r_rsp_pc;
  assign w_wr_fault = w_push_mis ? 1'b0 : i_imem_rsp_err;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_inst_mem[w_wr_idx]  <= w_wr_inst;
      r_pc_mem[w_wr_idx]    <= w_wr_pc;
      r_fault_mem[w_wr_idx] <= w_wr_fault;
      r_mis_mem[w_wr_idx]   <= w_push_mis;
    end
  end

  assign o_if_valid    = (r_count != '0);
  assign o_if_inst     = o_if_valid ? r_inst_mem[r_rd_ptr]  : '0;
  assign o_if_pc       = o_if_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign o_if_fault    = o_if_valid ? r_fault_mem[r_rd_ptr] : 1'b0;
  assign o_if_misalign = o_if_valid ? r_mis_mem[r_rd_ptr]   : 1'b0;

  // Credit accounting makes these impossible with a well-behaved memory.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push_rsp && !w_pop && ({1'b0, r_count} == DEPTH_W)));
  a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp_fire && (r_outstanding == '0)));

endmodule
